instr_sequencer: RTL and testbench



---
 rtl/seq_pkg.sv | 36 +++
 rtl/instr_sequencer_if.sv | 23 ++
 rtl/prog_mem.sv | 35 +++
 rtl/instr_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, instruction
// word field positions and the opcode encodings understood by `processor`.
package seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_ISSUE   = 3'd2,
      S_WAIT    = 3'd3,
      S_CAPTURE = 3'd4,
      S_DONE    = 3'd5,
      S_ERROR   = 3'd6
   } state_e;

   localparam int INSTR_W = 12;
   localparam int OPC_MSB = 11;
   localparam int OPC_LSB = 9;
   localparam int WEN_BIT = 8;
   localparam int A_MSB   = 7;
   localparam int A_LSB   = 4;
   localparam int B_MSB   = 3;
   localparam int B_LSB   = 0;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_REG  = 3'b100;
   localparam logic [2:0] OP_HALT = 3'b111;

   // True when an instruction word is the HALT marker.
   function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
      return instr[OPC_MSB:OPC_LSB] == OP_HALT;
   endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Link between the sequencer (master) and `processor` (slave): issued
// instruction fields one way, result and flags the other way.
interface instr_sequencer_if;
   logic [2:0] opcode;
   logic [3:0] a;
   logic [3:0] b;
   logic       wenable;
   logic [3:0] res;
   logic       cf;
   logic       zf;
   logic       sf;
   logic       invalid;

   modport master (
      output opcode, a, b, wenable,
      input  res, cf, zf, sf, invalid
   );

   modport slave (
      input  opcode, a, b, wenable,
      output res, cf, zf, sf, invalid
   );
endinterface

// File: rtl/prog_mem.sv
// Program store: one write port, one registered read port. A write to the
// address being read in the same cycle is forwarded, so a program word
// written on the start edge is what the first fetch sees.
module prog_mem #(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [11:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [11:0]   rdata_o
);
   logic [11:0] mem_q [DEPTH];
   logic [11:0] rdata_q;

   // Write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Registered read with write-first forwarding.
   always_ff @(posedge clk) begin
      if (we_i && (waddr_i == raddr_i)) begin
         rdata_q <= wdata_i;
      end else begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/instr_sequencer.sv
// Fetch/issue stage in front of `processor`. Steps through the program one
// instruction at a time: FETCH, ISSUE, WAIT_CYCLES cycles of WAIT, CAPTURE.
// The memory read address is the next-state PC, so the word for the PC is
// already in the read register when FETCH is entered.
module instr_sequencer
   import seq_pkg::*;
#(
   parameter  int DEPTH       = 16,
   parameter  int WAIT_CYCLES = 2,
   localparam int AW          = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                prog_we_i,
   input  logic [AW-1:0]       prog_addr_i,
   input  logic [INSTR_W-1:0]  prog_data_i,
   input  logic                start_i,
   instr_sequencer_if.master   proc,
   output logic                busy_o,
   output logic                done_o,
   output logic                overrun_o,
   output logic                error_o,
   output logic [AW-1:0]       pc_o,
   output logic [3:0]          last_res_o,
   output logic [2:0]          last_flags_o,
   output logic [4:0]          icount_o
);
   localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [4:0]    icount_q, icount_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          overrun_q, overrun_d;
   logic          error_q, error_d;
   logic [3:0]    last_res_q, last_res_d;
   logic [2:0]    last_flags_q, last_flags_d;
   logic [2:0]    opcode_q, opcode_d;
   logic [3:0]    a_q, a_d;
   logic [3:0]    b_q, b_d;
   logic          wen_q, wen_d;
   logic          ir_wen_q, ir_wen_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          idle_like;
   logic          mem_we;
   logic [INSTR_W-1:0] rdata;

   assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
   assign mem_we    = prog_we_i && idle_like;

   prog_mem #(.DEPTH(DEPTH)) u_prog_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (prog_addr_i),
      .wdata_i (prog_data_i),
      .raddr_i (pc_d),
      .rdata_o (rdata)
   );

   // Next-state and datapath decisions for the sequencing FSM.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      icount_d     = icount_q;
      done_d       = done_q;
      overrun_d    = overrun_q;
      error_d      = error_q;
      last_res_d   = last_res_q;
      last_flags_d = last_flags_q;
      opcode_d     = opcode_q;
      a_d          = a_q;
      b_d          = b_q;
      wen_d        = wen_q;
      ir_wen_d     = ir_wen_q;
      cnt_d        = cnt_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start_i) begin
               pc_d         = '0;
               icount_d     = 5'd0;
               done_d       = 1'b0;
               overrun_d    = 1'b0;
               error_d      = 1'b0;
               last_res_d   = 4'd0;
               last_flags_d = 3'd0;
               state_d      = S_FETCH;
            end else begin
               state_d = state_q;
            end
         end
         S_FETCH: begin
            if (is_halt(rdata)) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               // Loaded here so the fields are on the bus during ISSUE.
               opcode_d = rdata[OPC_MSB:OPC_LSB];
               a_d      = rdata[A_MSB:A_LSB];
               b_d      = rdata[B_MSB:B_LSB];
               wen_d    = rdata[WEN_BIT];
               ir_wen_d = rdata[WEN_BIT];
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            wen_d   = 1'b0;
            cnt_d   = 3'(WAIT_CYCLES);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == 3'd1) begin
               state_d = S_CAPTURE;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         S_CAPTURE: begin
            if (proc.invalid) begin
               error_d = 1'b1;
               state_d = S_ERROR;
            end else begin
               // A write-enabled instruction leaves res undriven.
               if (!ir_wen_q) begin
                  last_res_d   = proc.res;
                  last_flags_d = {proc.cf, proc.zf, proc.sf};
               end else begin
                  last_res_d   = last_res_q;
               end
               if (icount_q != 5'd31) begin
                  icount_d = icount_q + 5'd1;
               end else begin
                  icount_d = icount_q;
               end
               if (pc_q == PC_LAST) begin
                  overrun_d = 1'b1;
                  done_d    = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  pc_d    = pc_q + 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d == S_FETCH) || (state_d == S_ISSUE) ||
               (state_d == S_WAIT)  || (state_d == S_CAPTURE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         pc_q         <= '0;
         icount_q     <= 5'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         overrun_q    <= 1'b0;
         error_q      <= 1'b0;
         last_res_q   <= 4'd0;
         last_flags_q <= 3'd0;
         opcode_q     <= 3'd0;
         a_q          <= 4'd0;
         b_q          <= 4'd0;
         wen_q        <= 1'b0;
         ir_wen_q     <= 1'b0;
         cnt_q        <= 3'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         icount_q     <= icount_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         overrun_q    <= overrun_d;
         error_q      <= error_d;
         last_res_q   <= last_res_d;
         last_flags_q <= last_flags_d;
         opcode_q     <= opcode_d;
         a_q          <= a_d;
         b_q          <= b_d;
         wen_q        <= wen_d;
         ir_wen_q     <= ir_wen_d;
         cnt_q        <= cnt_d;
      end
   end

   assign proc.opcode  = opcode_q;
   assign proc.a       = a_q;
   assign proc.b       = b_q;
   assign proc.wenable = wen_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign overrun_o    = overrun_q;
   assign error_o      = error_q;
   assign pc_o         = pc_q;
   assign last_res_o   = last_res_q;
   assign last_flags_o = last_flags_q;
   assign icount_o     = icount_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed programs, a combinational processor
// stub, and a scoreboard compared whenever busy falls.
module tb_instr_sequencer;
   import seq_pkg::*;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        prog_we_i = 1'b0;
   logic [3:0]  prog_addr_i = 4'd0;
   logic [11:0] prog_data_i = 12'd0;
   logic        start_i = 1'b0;
   logic        busy_o, done_o, overrun_o, error_o;
   logic [3:0]  pc_o, last_res_o;
   logic [2:0]  last_flags_o;
   logic [4:0]  icount_o;

   int n_vec = 0;
   int n_err = 0;
   int wen_cycles = 0;

   typedef struct packed {
      logic       done;
      logic       overrun;
      logic       error;
      logic [3:0] pc;
      logic [3:0] res;
      logic [2:0] flags;
      logic [4:0] icount;
      logic [2:0] opcode;
      logic [3:0] a;
      logic [3:0] b;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_mon;
   logic busy_prev = 1'b0;

   always #5 clk = ~clk;

   instr_sequencer_if pif ();

   instr_sequencer #(.DEPTH(16), .WAIT_CYCLES(2)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .prog_we_i    (prog_we_i),
      .prog_addr_i  (prog_addr_i),
      .prog_data_i  (prog_data_i),
      .start_i      (start_i),
      .proc         (pif),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .overrun_o    (overrun_o),
      .error_o      (error_o),
      .pc_o         (pc_o),
      .last_res_o   (last_res_o),
      .last_flags_o (last_flags_o),
      .icount_o     (icount_o)
   );

   // Processor stub; unknown opcodes report invalid, REG drives junk.
   logic [4:0] stub_wide;
   always_comb begin
      stub_wide   = 5'd0;
      pif.invalid = 1'b0;
      case (pif.opcode)
         OP_AND:  stub_wide = {1'b0, pif.a & pif.b};
         OP_OR:   stub_wide = {1'b0, pif.a | pif.b};
         OP_ADD:  stub_wide = {1'b0, pif.a} + {1'b0, pif.b};
         OP_SUB:  stub_wide = {1'b0, pif.a} - {1'b0, pif.b};
         OP_REG:  stub_wide = 5'h0E;
         default: pif.invalid = 1'b1;
      endcase
   end
   assign pif.res = stub_wide[3:0];
   assign pif.cf  = stub_wide[4];
   assign pif.zf  = (stub_wide[3:0] == 4'd0);
   assign pif.sf  = stub_wide[3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [11:0] ins(input logic [2:0] op, input logic w,
                                       input logic [3:0] a, input logic [3:0] b);
      return {op, w, a, b};
   endfunction

   function automatic exp_t mk(input logic d, input logic ov, input logic er,
                               input logic [3:0] pc, input logic [3:0] res,
                               input logic [2:0] fl, input logic [4:0] ic,
                               input logic [2:0] op, input logic [3:0] a,
                               input logic [3:0] b);
      exp_t e;
      e = '{done: d, overrun: ov, error: er, pc: pc, res: res, flags: fl,
            icount: ic, opcode: op, a: a, b: b};
      return e;
   endfunction

   // Count cycles with wenable asserted.
   always @(negedge clk) begin
      if (pif.wenable) wen_cycles++;
   end

   // Scoreboard monitor: a falling busy presents a finished run.
   always @(negedge clk) begin
      if (busy_prev && !busy_o) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_completion", 32'd1, 32'd0);
         end else begin
            e_mon = exp_q.pop_front();
            chk("done",       32'(done_o),       32'(e_mon.done));
            chk("overrun",    32'(overrun_o),    32'(e_mon.overrun));
            chk("error",      32'(error_o),      32'(e_mon.error));
            chk("pc",         32'(pc_o),         32'(e_mon.pc));
            chk("last_res",   32'(last_res_o),   32'(e_mon.res));
            chk("last_flags", 32'(last_flags_o), 32'(e_mon.flags));
            chk("icount",     32'(icount_o),     32'(e_mon.icount));
            chk("opcode",     32'(pif.opcode),   32'(e_mon.opcode));
            chk("a",          32'(pif.a),        32'(e_mon.a));
            chk("b",          32'(pif.b),        32'(e_mon.b));
            chk("wenable",    32'(pif.wenable),  32'd0);
         end
      end
      busy_prev = busy_o;
   end

   task automatic write(input logic [3:0] ad, input logic [11:0] d);
      @(negedge clk);
      prog_we_i   = 1'b1;
      prog_addr_i = ad;
      prog_data_i = d;
      @(negedge clk);
      prog_we_i   = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!busy_o) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk({name, "_timeout"}, 32'd1, 32'd0);
      @(negedge clk);
   endtask

   task automatic run(input string name);
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      wait_idle(name);
   endtask

   initial begin
      bit ok;
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy",   32'(busy_o),     32'd0);
      chk("rst_done",   32'(done_o),     32'd0);
      chk("rst_pc",     32'(pc_o),       32'd0);
      chk("rst_icount", 32'(icount_o),   32'd0);
      chk("rst_opcode", 32'(pif.opcode), 32'd0);
      rstn = 1'b1;

      // ADD 3+4 then HALT, with issue timing
      write(4'd0, ins(OP_ADD, 1'b0, 4'd3, 4'd4));
      write(4'd1, ins(OP_HALT, 1'b0, 4'd0, 4'd0));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'd1, 4'd7, 3'b000, 5'd1, OP_ADD, 4'd3, 4'd4));
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk("t1_busy_after_start", 32'(busy_o),     32'd1);
      chk("t1_opcode_in_fetch",  32'(pif.opcode), 32'(OP_AND));
      @(negedge clk);
      chk("t1_opcode_in_issue",  32'(pif.opcode), 32'(OP_ADD));
      wait_idle("t1");

      // SUB 2-2 gives zero flag
      write(4'd0, ins(OP_SUB, 1'b0, 4'd2, 4'd2));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 3'b010, 5'd1, OP_SUB, 4'd2, 4'd2));
      run("t2");

      // Write-enabled REG does not update last_res, wenable pulses once
      write(4'd0, ins(OP_ADD, 1'b0, 4'd1, 4'd2));
      write(4'd1, ins(OP_REG, 1'b1, 4'd9, 4'd0));
      write(4'd2, ins(OP_HALT, 1'b0, 4'd0, 4'd0));
      wen_cycles = 0;
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'd2, 4'd3, 3'b000, 5'd2, OP_REG, 4'd9, 4'd0));
      run("t3");
      chk("t3_wenable_cycles", 32'(wen_cycles), 32'd1);

      // Invalid at second capture
      write(4'd0, ins(OP_ADD, 1'b0, 4'd1, 4'd1));
      write(4'd1, ins(3'b101, 1'b0, 4'd0, 4'd0));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 4'd1, 4'd2, 3'b000, 5'd1, 3'b101, 4'd0, 4'd0));
      run("t4");
      chk("t4_busy", 32'(busy_o), 32'd0);

      // Full memory without HALT: overrun, no wrap
      for (int i = 0; i < 16; i++) write(4'(i), ins(OP_AND, 1'b0, 4'hF, 4'hF));
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 4'd15, 4'hF, 3'b001, 5'd16, OP_AND, 4'hF, 4'hF));
      run("t5");
      repeat (10) @(negedge clk);
      chk("t5_pc_no_wrap",   32'(pc_o),     32'd15);
      chk("t5_busy_no_wrap", 32'(busy_o),   32'd0);
      chk("t5_icount_hold",  32'(icount_o), 32'd16);

      // Reset during WAIT of the third instruction, then rerun
      write(4'd0, ins(OP_ADD, 1'b0, 4'd1, 4'd1));
      write(4'd1, ins(OP_ADD, 1'b0, 4'd2, 4'd2));
      write(4'd2, ins(OP_ADD, 1'b0, 4'd3, 4'd3));
      write(4'd3, ins(OP_HALT, 1'b0, 4'd0, 4'd0));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 3'b000, 5'd0, 3'd0, 4'd0, 4'd0));
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (pc_o == 4'd2) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) chk("t6_pc2_timeout", 32'd1, 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      chk("t6_rst_wenable", 32'(pif.wenable), 32'd0);
      chk("t6_rst_busy",    32'(busy_o),      32'd0);
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'd3, 4'd6, 3'b000, 5'd3, OP_ADD, 4'd3, 4'd3));
      run("t6_rerun");

      // start and prog_we on the same edge: HALT at address 0
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 3'b000, 5'd0, OP_ADD, 4'd3, 4'd3));
      @(negedge clk);
      start_i     = 1'b1;
      prog_we_i   = 1'b1;
      prog_addr_i = 4'd0;
      prog_data_i = ins(OP_HALT, 1'b0, 4'd0, 4'd0);
      @(negedge clk);
      start_i     = 1'b0;
      prog_we_i   = 1'b0;
      wait_idle("t7");

      // Writes while busy are dropped; rerun shows memory intact
      write(4'd0, ins(OP_ADD, 1'b0, 4'd5, 4'd6));
      write(4'd1, ins(OP_HALT, 1'b0, 4'd0, 4'd0));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'd1, 4'hB, 3'b001, 5'd1, OP_ADD, 4'd5, 4'd6));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 4'd1, 4'hB, 3'b001, 5'd1, OP_ADD, 4'd5, 4'd6));
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i     = 1'b0;
      prog_we_i   = 1'b1;
      prog_addr_i = 4'd1;
      prog_data_i = ins(OP_ADD, 1'b0, 4'd1, 4'd1);
      @(negedge clk);
      prog_addr_i = 4'd0;
      prog_data_i = ins(OP_OR, 1'b0, 4'd1, 4'd0);
      @(negedge clk);
      prog_we_i   = 1'b0;
      wait_idle("t8");
      run("t8_rerun");

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end
endmodule
